i2c_master_burst_read: RTL and testbench
========================================

// Module: i2c_master_burst_read
// PURPOSE
//  Parametrised I2C master for random-address burst reads: START, dev+W, 1..2 register-address bytes,
//  repeated START, dev+R, then 1..2^LEN_W data bytes with master ACK/NACK, then STOP.
//  Generalises the single-byte receive master: configurable address width, burst length,
//  per-byte streaming output, NACK error reporting and an open-drain SDA.
//  Sits between a register-access controller and the board I2C pins (sensor/EEPROM reads).
// PARAMETERS
//  CLK_DIV     500  clk cycles per SCL period; even, >= 8
//  ADDR_BYTES  1    register-address bytes sent MSB first; legal values 1 or 2
//  LEN_W       4    width of i_len; burst length = i_len+1 (1..2^LEN_W bytes)
// PORTS
//  clk            in     1      system clock, one clock domain
//  rst            in     1      asynchronous, active-high reset
//  i_start        in     1      1-cycle request; sampled only in IDLE
//  i_device_addr  in     7      7-bit slave address
//  i_reg_addr     in     16     register address; only low 8 bits used when ADDR_BYTES=1
//  i_len          in     LEN_W  bytes to read minus one
//  o_busy         out    1      high from the cycle after accepted i_start until DONE exits
//  o_rd_data      out    8      last received byte, MSB first on the bus
//  o_rd_valid     out    1      1-cycle pulse, o_rd_data is new
//  o_done         out    1      1-cycle pulse at end of transaction (success or error)
//  o_nack_err     out    1      set with o_done if any write-phase ACK was NACK; cleared on next accept
//  o_scl          out    1      SCL, push-pull
//  o_sda_oe       out    1      1 = master pulls SDA low
//  io_sda         inout  1      io_sda = o_sda_oe ? 1'b0 : 1'bz (open drain, external pull-up)
// BEHAVIOUR
//  Reset: o_scl=1, o_sda_oe=0, o_busy=0, o_rd_data=0, o_rd_valid=0, o_done=0, o_nack_err=0; FSM=IDLE.
//   Reset mid-transfer aborts immediately. No STOP is issued; the bus is released (SCL=1, SDA=Z).
//  Timing: counter cnt runs 0..CLK_DIV-1 only while busy, held at 0 otherwise.
//   o_scl = (cnt < CLK_DIV/2) while busy, 1 while idle.
//   HM = cnt==CLK_DIV/4 (SCL high mid): sample / START / STOP edges.
//   LM = cnt==3*CLK_DIV/4 (SCL low mid): SDA changes.
//  Accept: i_start in IDLE latches dev, reg addr and len, clears o_nack_err, goes to START.
//   i_start while busy is ignored.
//  States / transitions:
//   IDLE    -> START on i_start.
//   START   : SDA released; at HM pull low (START); -> WR_BYTE with shift reg = {dev,0}.
//   WR_BYTE : at each LM drive next bit (0=pull low, 1=release), 8 bits MSB first; after 8th -> WR_ACK.
//   WR_ACK  : release at LM; sample io_sda at HM.
//     - 1 (NACK): set o_nack_err, -> STOP.
//     - 0 (ACK): next byte (reg addr MSB, then LSB), or -> RESTART after the last address byte, or -> RD_BYTE after dev+R.
//   RESTART : release at LM; at next HM pull low (repeated START); -> WR_BYTE with {dev,1}.
//   RD_BYTE : SDA released; shift in io_sda at 8 successive HMs.
//     - On the 8th sample: o_rd_data updates and o_rd_valid pulses the next cycle; -> RD_ACK.
//   RD_ACK  : at LM pull low (ACK) if bytes remain, else release (NACK).
//     - After one SCL period -> RD_BYTE (remaining count decremented) or STOP.
//   STOP    : at LM pull low; at next HM release (SDA rises with SCL high); -> DONE.
//   DONE    : o_done=1 for one cycle, counter stopped, o_busy=0 next cycle; -> IDLE.
//  Byte counter: LEN_W bits, loaded with i_len, decremented per byte; last byte when it equals 0.
//  No clock stretching or arbitration; SCL is never sampled.
// TESTING (CLK_DIV=8 unless noted)
//  1. dev=0x50, ADDR_BYTES=1, reg=0x3A, len=0, slave ACKs, returns 0xA5
//     -> bus bytes 0xA0, 0x3A, Sr, 0xA1; one o_rd_valid with 0xA5; final NACK, STOP, o_done, o_nack_err=0.
//  2. ADDR_BYTES=2, reg=0x1234, len=3, slave returns 0x11,0x22,0x33,0x44
//     -> 4 o_rd_valid pulses in order; ACK after bytes 1-3, NACK after byte 4.
//  3. No slave (SDA floats high) -> NACK on dev+W; o_nack_err=1 with o_done; STOP issued; no o_rd_valid.
//  4. Second i_start pulsed mid-burst -> ignored; exactly one transaction, one o_done.
//  5. rst asserted during RD_BYTE -> same cycle: o_busy=0, o_scl=1, o_sda_oe=0.
//     Next i_start runs a full correct transaction.
//  6. LEN_W=4, len=15 -> 16 bytes received.
//     Counter wraps nothing.
//     Check o_busy is low exactly one cycle after o_done.

Source files
------------

// File: rtl/i2c_master_burst_read.sv
// I2C master for random-address burst reads: START, dev+W, register address, repeated START,
// dev+R, 1..2^LEN_W data bytes (ACK all but the last), STOP. Open-drain SDA, push-pull SCL.
module i2c_master_burst_read #(
  parameter int CLK_DIV    = 500,
  parameter int ADDR_BYTES = 1,
  parameter int LEN_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [6:0]       i_device_addr,
  input  logic [15:0]      i_reg_addr,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic [7:0]       o_rd_data,
  output logic             o_rd_valid,
  output logic             o_done,
  output logic             o_nack_err,
  output logic             o_scl,
  output logic             o_sda_oe,
  inout  wire              io_sda
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST_C = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_C = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] HM_C   = CW'(CLK_DIV / 4);
  localparam logic [CW-1:0] LM_C   = CW'(3 * CLK_DIV / 4);
  localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES);
  localparam logic [1:0]    SEL_DEV_R = 2'd3;

  typedef enum logic [3:0] {
    IDLE, START, WR_BYTE, WR_ACK, RESTART, RD_BYTE, RD_ACK, STOP, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic             phase_q, phase_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]       dev_q, dev_d;
  logic [15:0]      reg_q, reg_d;
  logic             sda_oe_q, sda_oe_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             nack_err_q, nack_err_d;
  logic             hm, lm, sda_in, counting;

  assign sda_in   = io_sda;
  assign io_sda   = sda_oe_q ? 1'b0 : 1'bz;
  assign hm       = (cnt_q == HM_C);
  assign lm       = (cnt_q == LM_C);
  assign counting = (state_q != IDLE) && (state_q != DONE);

  assign o_busy     = (state_q != IDLE);
  assign o_done     = (state_q == DONE);
  assign o_scl      = counting ? (cnt_q < HALF_C) : 1'b1;
  assign o_sda_oe   = sda_oe_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_nack_err = nack_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    wr_sel_d   = wr_sel_q;
    phase_d    = phase_q;
    byte_cnt_d = byte_cnt_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    sda_oe_d   = sda_oe_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    nack_err_d = nack_err_q;

    if (counting) begin
      cnt_d = (cnt_q == LAST_C) ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        sda_oe_d = 1'b0;
        if (i_start) begin
          state_d    = START;
          dev_d      = i_device_addr;
          reg_d      = i_reg_addr;
          byte_cnt_d = i_len;
          nack_err_d = 1'b0;
          phase_d    = 1'b0;
        end
      end
      START: begin
        if (hm) begin
          sda_oe_d  = 1'b1;
          shift_d   = {dev_q, 1'b0};
          bit_cnt_d = '0;
          wr_sel_d  = '0;
          state_d   = WR_BYTE;
        end
      end
      WR_BYTE: begin
        if (lm) begin
          sda_oe_d  = ~shift_q[7];
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = WR_ACK;
            phase_d = 1'b0;
          end
        end
      end
      // phase_q marks that SDA was released, so the next HM is the ACK clock
      WR_ACK: begin
        if (lm) begin
          sda_oe_d = 1'b0;
          phase_d  = 1'b1;
        end else if (hm && phase_q) begin
          phase_d = 1'b0;
          if (sda_in) begin
            nack_err_d = 1'b1;
            state_d    = STOP;
          end else if (wr_sel_q == SEL_DEV_R) begin
            bit_cnt_d = '0;
            state_d   = RD_BYTE;
          end else if (wr_sel_q == ADDR_LAST) begin
            state_d = RESTART;
          end else begin
            wr_sel_d = wr_sel_q + 2'd1;
            shift_d  = (wr_sel_q == 2'd0 && ADDR_BYTES == 2) ? reg_q[15:8] : reg_q[7:0];
            state_d  = WR_BYTE;
          end
        end
      end
      RESTART: begin
        if (lm) begin
          sda_oe_d = 1'b0;
          phase_d  = 1'b1;
        end else if (hm && phase_q) begin
          phase_d   = 1'b0;
          sda_oe_d  = 1'b1;
          shift_d   = {dev_q, 1'b1};
          bit_cnt_d = '0;
          wr_sel_d  = SEL_DEV_R;
          state_d   = WR_BYTE;
        end
      end
      RD_BYTE: begin
        sda_oe_d = 1'b0;
        if (hm) begin
          shift_d   = {shift_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rd_data_d  = {shift_q[6:0], sda_in};
            rd_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = RD_ACK;
          end
        end
      end
      // First LM drives ACK/NACK, second LM ends the ACK clock
      RD_ACK: begin
        if (lm) begin
          if (!phase_q) begin
            sda_oe_d = (byte_cnt_q != '0);
            phase_d  = 1'b1;
          end else if (byte_cnt_q != '0) begin
            sda_oe_d   = 1'b0;
            phase_d    = 1'b0;
            byte_cnt_d = byte_cnt_q - LEN_W'(1);
            bit_cnt_d  = '0;
            state_d    = RD_BYTE;
          end else begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
            state_d  = STOP;
          end
        end
      end
      STOP: begin
        if (lm && !phase_q) begin
          sda_oe_d = 1'b1;
          phase_d  = 1'b1;
        end else if (hm && phase_q) begin
          sda_oe_d = 1'b0;
          phase_d  = 1'b0;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      wr_sel_q   <= '0;
      phase_q    <= 1'b0;
      byte_cnt_q <= '0;
      dev_q      <= '0;
      reg_q      <= '0;
      sda_oe_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      nack_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      wr_sel_q   <= wr_sel_d;
      phase_q    <= phase_d;
      byte_cnt_q <= byte_cnt_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      sda_oe_q   <= sda_oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      nack_err_q <= nack_err_d;
    end
  end

endmodule

// File: tb/tb_i2c_master_burst_read.sv
// Bench for i2c_master_burst_read: two masters (1- and 2-byte register address) share one bus
// with a behavioural I2C slave that logs every bus event for comparison against expected traffic.
module tb_i2c_master_burst_read;

  localparam logic [31:0] EV_S = 32'h1000;
  localparam logic [31:0] EV_P = 32'h2000;
  localparam logic [31:0] EV_R = 32'h0400;
  localparam logic [31:0] EV_NACK = 32'h0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [6:0]  dev_in = '0;
  logic [15:0] reg_in = '0;
  logic [3:0]  len_in = '0;

  logic        busy1, rv1, done1, nack1, scl1, oe1;
  logic        busy2, rv2, done2, nack2, scl2, oe2;
  logic [7:0]  rd1, rd2;
  wire         sda_bus;
  wire         scl;
  logic        slv_pull = 1'b0;

  pullup pu_sda (sda_bus);
  assign sda_bus = slv_pull ? 1'b0 : 1'bz;
  assign scl = scl1 & scl2;

  always #5 clk = ~clk;

  i2c_master_burst_read #(.CLK_DIV(8), .ADDR_BYTES(1), .LEN_W(4)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_device_addr(dev_in), .i_reg_addr(reg_in),
    .i_len(len_in), .o_busy(busy1), .o_rd_data(rd1), .o_rd_valid(rv1), .o_done(done1),
    .o_nack_err(nack1), .o_scl(scl1), .o_sda_oe(oe1), .io_sda(sda_bus));

  i2c_master_burst_read #(.CLK_DIV(8), .ADDR_BYTES(2), .LEN_W(4)) dut2 (
    .clk(clk), .rst(rst), .i_start(start2), .i_device_addr(dev_in), .i_reg_addr(reg_in),
    .i_len(len_in), .o_busy(busy2), .o_rd_data(rd2), .o_rd_valid(rv2), .o_done(done2),
    .o_nack_err(nack2), .o_scl(scl2), .o_sda_oe(oe2), .io_sda(sda_bus));

  logic sel2 = 1'b0;
  wire       sel_busy = sel2 ? busy2 : busy1;
  wire       sel_done = sel2 ? done2 : done1;
  wire       sel_nack = sel2 ? nack2 : nack1;
  wire       sel_scl  = sel2 ? scl2  : scl1;
  wire       sel_oe   = sel2 ? oe2   : oe1;
  wire [7:0] sel_rd   = sel2 ? rd2   : rd1;

  int tests = 0;
  int fails = 0;

  // Behavioural slave: protocol-level view of the bus, sampled every clk.
  logic [31:0] bus_ev[$];
  logic [7:0]  slv_data[$];
  logic [6:0]  slv_dev = '0;
  bit          slv_present = 1'b0;
  bit          p_scl = 1'b1, p_sda = 1'b1;
  int          bitpos = 0;
  bit          frame_rd = 1'b0, first_byte = 1'b0, pending_rd = 1'b0, ack_seen = 1'b1, ok;
  logic [7:0]  sh = '0, cur = '0;
  bit          sda_now;

  always @(posedge clk) begin
    if (rst) begin
      slv_pull <= 1'b0;
      bitpos = 0; frame_rd = 0; pending_rd = 0; first_byte = 0;
      p_scl = 1'b1; p_sda = 1'b1;
    end else begin
      sda_now = (sda_bus !== 1'b0);
      if (scl && p_scl && p_sda && !sda_now) begin
        bus_ev.push_back(EV_S);
        bitpos = 0; frame_rd = 0; first_byte = 1; pending_rd = 0;
        slv_pull <= 1'b0;
      end else if (scl && p_scl && !p_sda && sda_now) begin
        bus_ev.push_back(EV_P);
        bitpos = 0; frame_rd = 0; pending_rd = 0;
        slv_pull <= 1'b0;
      end else if (scl && !p_scl) begin
        if (bitpos < 8) begin
          if (!frame_rd) sh = {sh[6:0], sda_now};
        end else if (bitpos == 8) begin
          ack_seen = sda_now;
          bus_ev.push_back((frame_rd ? (EV_R | 32'(cur)) : 32'(sh)) | (sda_now ? EV_NACK : 32'h0));
        end
        bitpos++;
      end else if (!scl && p_scl) begin
        if (bitpos == 8) begin
          if (!frame_rd) begin
            ok = slv_present && (!first_byte || sh[7:1] == slv_dev);
            slv_pull <= ok;
            pending_rd = first_byte && sh[0] && ok;
            first_byte = 0;
          end else begin
            slv_pull <= 1'b0;
          end
        end else if (bitpos == 9) begin
          bitpos = 0;
          if (pending_rd || (frame_rd && !ack_seen)) begin
            frame_rd = 1; pending_rd = 0;
            cur = (slv_data.size() > 0) ? slv_data.pop_front() : 8'hFF;
            slv_pull <= !cur[7];
          end else begin
            frame_rd = 0;
            slv_pull <= 1'b0;
          end
        end else if (frame_rd && bitpos >= 1 && bitpos <= 7) begin
          slv_pull <= !cur[7-bitpos];
        end
      end
      p_scl = scl;
      p_sda = sda_now;
    end
  end

  logic [7:0] rx1[$], rx2[$];
  always @(negedge clk) begin
    if (rv1) rx1.push_back(rd1);
    if (rv2) rx2.push_back(rd2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel2) start2 = v; else start1 = v;
  endtask

  task automatic start_txn(input string name);
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    check({name, ":busy_after_accept"}, 32'(sel_busy), 32'd1);
    check({name, ":nack_cleared"}, 32'(sel_nack), 32'd0);
  endtask

  logic [7:0] data_q[$];

  task automatic setup(input bit use2, input logic [6:0] dev, input logic [15:0] ra,
                       input logic [3:0] len, input bit present);
    sel2 = use2; dev_in = dev; reg_in = ra; len_in = len;
    slv_present = present; slv_dev = dev; slv_data = data_q;
    bus_ev.delete(); rx1.delete(); rx2.delete();
  endtask

  task automatic run_full(input string name, input bit use2, input logic [6:0] dev,
                          input logic [15:0] ra, input logic [3:0] len, input bit present,
                          input int mid_at);
    logic [31:0] exp_ev[$];
    logic [7:0]  got_rx[$];
    bit got;
    int ndone, nexp;
    setup(use2, dev, ra, len, present);
    exp_ev.push_back(EV_S);
    if (!present) begin
      exp_ev.push_back(32'({dev, 1'b0}) | EV_NACK);
    end else begin
      exp_ev.push_back(32'({dev, 1'b0}));
      if (use2) exp_ev.push_back(32'(ra[15:8]));
      exp_ev.push_back(32'(ra[7:0]));
      exp_ev.push_back(EV_S);
      exp_ev.push_back(32'({dev, 1'b1}));
      for (int i = 0; i <= int'(len); i++)
        exp_ev.push_back(EV_R | 32'(data_q[i]) | ((i == int'(len)) ? EV_NACK : 32'h0));
    end
    exp_ev.push_back(EV_P);

    start_txn(name);
    got = 0; ndone = 0;
    for (int n = 0; n < 6000 && !got; n++) begin
      @(negedge clk);
      if (n == mid_at) set_start(1'b1);
      else if (n == mid_at + 1) set_start(1'b0);
      if (sel_done) got = 1;
    end
    check({name, ":done_seen"}, 32'(got), 32'd1);
    if (got) begin
      ndone = 1;
      check({name, ":busy_at_done"}, 32'(sel_busy), 32'd1);
      check({name, ":nack_err"}, 32'(sel_nack), 32'(!present));
      @(negedge clk);
      check({name, ":busy_after_done"}, 32'(sel_busy), 32'd0);
      check({name, ":scl_idle"}, 32'(sel_scl), 32'd1);
      check({name, ":sda_released"}, 32'(sel_oe), 32'd0);
    end
    set_start(1'b0);
    repeat (40) begin
      @(negedge clk);
      if (sel_done) ndone++;
    end
    check({name, ":done_count"}, 32'(ndone), 32'd1);
    check({name, ":nack_err_held"}, 32'(sel_nack), 32'(!present));

    if (use2) got_rx = rx2; else got_rx = rx1;
    nexp = present ? int'(len) + 1 : 0;
    check({name, ":rd_count"}, 32'(got_rx.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < got_rx.size(); i++)
      check($sformatf("%s:rd%0d", name, i), 32'(got_rx[i]), 32'(data_q[i]));
    if (present) check({name, ":rd_data_last"}, 32'(sel_rd), 32'(data_q[len]));

    check({name, ":ev_count"}, 32'(bus_ev.size()), 32'(exp_ev.size()));
    for (int i = 0; i < exp_ev.size() && i < bus_ev.size(); i++)
      check($sformatf("%s:ev%0d", name, i), bus_ev[i], exp_ev[i]);
    $display("[TB] txn %s dev=%02h reg=%04h len=%0d present=%0d done", name, dev, ra, len, present);
  endtask

  task automatic rand_data(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst:busy1", 32'(busy1), 0);    check("rst:busy2", 32'(busy2), 0);
    check("rst:scl1", 32'(scl1), 1);      check("rst:oe1", 32'(oe1), 0);
    check("rst:rd_data1", 32'(rd1), 0);   check("rst:rd_valid1", 32'(rv1), 0);
    check("rst:done1", 32'(done1), 0);    check("rst:nack1", 32'(nack1), 0);
    check("rst:scl2", 32'(scl2), 1);      check("rst:oe2", 32'(oe2), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    data_q = '{8'hA5};
    run_full("t1_single", 1'b0, 7'h50, 16'h003A, 4'd0, 1'b1, -1);

    data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_full("t2_addr16", 1'b1, 7'h50, 16'h1234, 4'd3, 1'b1, -1);

    data_q.delete();
    run_full("t3_noslave", 1'b0, 7'h50, 16'h003A, 4'd2, 1'b0, -1);

    rand_data(5);
    run_full("t4_midstart", 1'b1, 7'($urandom), 16'($urandom), 4'd4, 1'b1, 150);

    // Asynchronous reset in the middle of the second data byte.
    rand_data(4);
    setup(1'b1, 7'h2C, 16'hBEEF, 4'd3, 1'b1);
    start_txn("t5_abort");
    for (int n = 0; n < 3000 && rx2.size() == 0; n++) @(negedge clk);
    check("t5_abort:first_byte", 32'(rx2.size()), 32'd1);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_abort:busy", 32'(busy2), 32'd0);
    check("t5_abort:scl", 32'(scl2), 32'd1);
    check("t5_abort:sda_oe", 32'(oe2), 32'd0);
    $display("[TB] txn t5_abort reset applied mid-read");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rand_data(3);
    run_full("t5_after", 1'b1, 7'($urandom), 16'($urandom), 4'd2, 1'b1, -1);

    rand_data(16);
    run_full("t6_len16", 1'b0, 7'($urandom), 16'($urandom), 4'd15, 1'b1, -1);

    for (int k = 0; k < 4; k++) begin
      logic [3:0] l;
      l = 4'($urandom_range(0, 6));
      rand_data(int'(l) + 1);
      run_full($sformatf("rand%0d", k), 1'(k & 1), 7'($urandom), 16'($urandom), l, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
